// File: rtl/sram_march_bist.sv
// March C- SRAM BIST: 10N back-to-back ops, first op one cycle after the start edge; done_o 10N+READ_LAT+1 cycles after it.
// No backpressure: the engine runs free, and the SRAM port is owned for the whole test.
module sram_march_bist #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              pattern_i,
  input  logic [DATA_W-1:0] sram_dout_i,
  output logic              bist_en_o,
  output logic              bist_men_o,
  output logic              bist_wen_o,
  output logic              bist_ren_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic [DATA_W-1:0] bist_bm_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        elem_q;
  logic              phase_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ops_done_q;
  logic [1:0]        drain_q;
  logic              pat_q;

  logic              start_acc, op_vld, op_wr, op_inv, last_in_elem, addr_end, mismatch;
  logic [DATA_W-1:0] op_dat;

  logic [READ_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0]   pipe_exp  [READ_LAT];
  logic [ADDR_W-1:0]   pipe_addr [READ_LAT];

  // Solid background is all zeros; checkerboard starts with bit 0 set on even addresses.
  function automatic logic [DATA_W-1:0] background(input logic pat, input logic odd);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W; i++) v[i] = pat & (odd ^ (i % 2 == 0));
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    op_vld    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (ops_done_q) state_d = DRAIN;
        else            op_vld  = 1'b1;
      end
      DRAIN:   if (drain_q == 2'(READ_LAT - 1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Elements 0 and 5 are single-op; 1..4 are read-then-write with phase_q selecting the op.
  assign op_wr        = (elem_q == 3'd0) | ((elem_q != 3'd5) & phase_q);
  assign op_inv       = ((elem_q == 3'd1) | (elem_q == 3'd3)) ? phase_q :
                        ((elem_q == 3'd2) | (elem_q == 3'd4)) ? ~phase_q : 1'b0;
  assign last_in_elem = (elem_q == 3'd0) | (elem_q == 3'd5) | phase_q;
  assign addr_end     = (elem_q < 3'd3) ? (addr_q == '1) : (addr_q == '0);
  assign op_dat       = background(pat_q, addr_q[0]) ^ {DATA_W{op_inv}};
  assign mismatch     = pipe_vld[READ_LAT-1] && (sram_dout_i != pipe_exp[READ_LAT-1]);
  assign bist_en_o    = busy_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q     <= 3'd0;
      phase_q    <= 1'b0;
      addr_q     <= '0;
      ops_done_q <= 1'b0;
      pat_q      <= 1'b0;
      drain_q    <= 2'd0;
    end else begin
      drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
      if (start_acc) begin
        elem_q     <= 3'd0;
        phase_q    <= 1'b0;
        addr_q     <= '0;
        ops_done_q <= 1'b0;
        pat_q      <= pattern_i;
      end else if (op_vld) begin
        if (!last_in_elem) begin
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (addr_end) begin
            if (elem_q == 3'd5) begin
              ops_done_q <= 1'b1;
            end else begin
              elem_q <= elem_q + 3'd1;
              addr_q <= (elem_q < 3'd2) ? '0 : '1;
            end
          end else begin
            addr_q <= (elem_q < 3'd3) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
      bist_addr_o <= '0;
      bist_din_o  <= '0;
      bist_bm_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      bist_men_o  <= op_vld;
      bist_wen_o  <= op_vld & op_wr;
      bist_ren_o  <= op_vld & ~op_wr;
      bist_addr_o <= op_vld ? addr_q : '0;
      bist_din_o  <= (op_vld & op_wr) ? op_dat : '0;
      bist_bm_o   <= {DATA_W{state_d == RUN}};
      busy_o      <= (state_d == RUN) | (state_d == DRAIN);
      done_o      <= (state_d == DONE);
    end
  end

  // Expected word and address travel with each read until its data returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        pipe_exp[k]  <= '0;
        pipe_addr[k] <= '0;
      end
    end else begin
      pipe_vld[0]  <= op_vld & ~op_wr;
      pipe_exp[0]  <= op_dat;
      pipe_addr[0] <= addr_q;
      for (int k = 1; k < READ_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_exp[k]  <= pipe_exp[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else if (start_acc) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else if (mismatch) begin
      fail_o <= 1'b1;
      if (!fail_o) begin
        fail_addr_o <= pipe_addr[READ_LAT-1];
        fail_data_o <= sram_dout_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (READ_LAT 1 and 3) on faulty behavioural SRAMs,
// table-driven directed runs, a mid-test reset sequence and randomized runs against a march model.
module tb_sram_march_bist;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          st1 = 1'b0, st3 = 1'b0, pat_in = 1'b0, sel = 1'b0;
  logic          en1, men1, wen1, ren1, busy1, done1, fail1;
  logic          en3, men3, wen3, ren3, busy3, done3, fail3;
  logic [AW-1:0] addr1, faddr1, addr3, faddr3;
  logic [DW-1:0] dout1, din1, bm1, fdata1, dout3, din3, bm3, fdata3;

  sram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .pattern_i(pat_in), .sram_dout_i(dout1),
    .bist_en_o(en1), .bist_men_o(men1), .bist_wen_o(wen1), .bist_ren_o(ren1),
    .bist_addr_o(addr1), .bist_din_o(din1), .bist_bm_o(bm1), .busy_o(busy1),
    .done_o(done1), .fail_o(fail1), .fail_addr_o(faddr1), .fail_data_o(fdata1));

  sram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st3), .pattern_i(pat_in), .sram_dout_i(dout3),
    .bist_en_o(en3), .bist_men_o(men3), .bist_wen_o(wen3), .bist_ren_o(ren3),
    .bist_addr_o(addr3), .bist_din_o(din3), .bist_bm_o(bm3), .busy_o(busy3),
    .done_o(done3), .fail_o(fail3), .fail_addr_o(faddr3), .fail_data_o(fdata3));

  // Fault setup: fk 0 = none, 1 = stuck-at (fa, fb, fv), 2 = coupling (write of nonzero to ca flips bit fb of cv).
  int            fk = 0;
  int            fb = 0;
  logic [AW-1:0] fa = '0, ca = '0, cv = '0;
  logic          fv = 1'b0;

  function automatic logic [DW-1:0] wr_fault(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fk == 1 && a == fa) r[fb] = fv;
    return r;
  endfunction

  logic [DW-1:0] mem1 [N];
  logic [DW-1:0] mem3 [N];
  logic [DW-1:0] p1 = '0, p2 = '0;

  always @(posedge clk) begin
    if (men1 && wen1) begin
      mem1[addr1] <= wr_fault(addr1, din1);
      if (fk == 2 && addr1 == ca && din1 != '0) mem1[cv][fb] <= ~mem1[cv][fb];
    end
    if (men3 && wen3) begin
      mem3[addr3] <= wr_fault(addr3, din3);
      if (fk == 2 && addr3 == ca && din3 != '0) mem3[cv][fb] <= ~mem3[cv][fb];
    end
    p1 <= (men3 && ren3) ? mem3[addr3] : '0;
    p2 <= p1;
  end
  assign dout1 = (men1 && ren1) ? mem1[addr1] : '0;
  assign dout3 = p2;

  logic          v_en, v_men, v_wen, v_ren, v_busy, v_done, v_fail;
  logic [AW-1:0] v_addr, v_faddr;
  logic [DW-1:0] v_din, v_bm, v_fdata;
  always_comb begin
    v_en    = sel ? en3    : en1;
    v_men   = sel ? men3   : men1;
    v_wen   = sel ? wen3   : wen1;
    v_ren   = sel ? ren3   : ren1;
    v_busy  = sel ? busy3  : busy1;
    v_done  = sel ? done3  : done1;
    v_fail  = sel ? fail3  : fail1;
    v_addr  = sel ? addr3  : addr1;
    v_faddr = sel ? faddr3 : faddr1;
    v_din   = sel ? din3   : din1;
    v_bm    = sel ? bm3    : bm1;
    v_fdata = sel ? fdata3 : fdata1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs(input bit s3);
    if (s3) return {en3, men3, wen3, ren3, addr3, din3, bm3, busy3, done3, fail3, faddr3, fdata3};
    return {en1, men1, wen1, ren1, addr1, din1, bm1, busy1, done1, fail1, faddr1, fdata1};
  endfunction

  // Reference: the March C- op list plus the first mismatch an ideal checker would see on the faulty memory.
  typedef struct { bit wr; int a; logic [DW-1:0] d; } op_t;
  op_t           exp_ops[$];
  bit            rf_fail;
  logic [AW-1:0] rf_fa;
  logic [DW-1:0] rf_fd;

  function automatic logic [DW-1:0] bgv(input bit pat, input int a);
    return pat ? ((a % 2 == 1) ? 16'hAAAA : 16'h5555) : 16'h0000;
  endfunction

  task automatic build_ref(input bit pat);
    int            codes [6][2];
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] v;
    op_t           o;
    int            a;
    codes = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};  // 0=r0 1=r1 2=w0 3=w1
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    exp_ops.delete();
    rf_fail = 0; rf_fa = '0; rf_fd = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e < 3) ? i : N - 1 - i;
        for (int k = 0; k < 2; k++) begin
          if (codes[e][k] >= 0) begin
            v    = bgv(pat, a) ^ ((codes[e][k] % 2 == 1) ? 16'hFFFF : 16'h0000);
            o.wr = (codes[e][k] >= 2);
            o.a  = a;
            o.d  = v;
            exp_ops.push_back(o);
            if (o.wr) begin
              ref_mem[a] = wr_fault(a[AW-1:0], v);
              if (fk == 2 && a[AW-1:0] == ca && v != '0) ref_mem[cv][fb] = ~ref_mem[cv][fb];
            end else if (ref_mem[a] != v && !rf_fail) begin
              rf_fail = 1; rf_fa = a[AW-1:0]; rf_fd = ref_mem[a];
            end
          end
        end
      end
    end
  endtask

  task automatic set_start(input bit s3, input logic v);
    if (s3) st3 = v;
    else    st1 = v;
  endtask

  task automatic run(input bit s3, input bit pat, input bit mid_start,
                     input bit efail, input logic [AW-1:0] efa, input logic [DW-1:0] efd);
    int            lat, nops, operr, done_c, c;
    logic [DW-1:0] w0, w1;
    op_t           o;
    lat = s3 ? 3 : 1;
    sel = s3;
    nops = 0; operr = 0; done_c = -1; w0 = '0; w1 = '0;
    @(negedge clk);
    pat_in = pat;
    set_start(s3, 1'b1);
    @(posedge clk); #1;
    set_start(s3, 1'b0);
    chk("start_clears_status", {v_done, v_fail, v_faddr, v_fdata}, '0);
    chk("busy_en_at_start", {v_busy, v_en}, 2'b11);
    for (c = 1; done_c < 0 && c <= 10 * N + lat + 20; c++) begin
      @(posedge clk); #1;
      if (v_men) begin
        if (nops < exp_ops.size()) begin
          o = exp_ops[nops];
          if (c != nops + 1 || v_wen != o.wr || v_ren == o.wr || int'(v_addr) != o.a ||
              v_din != (o.wr ? o.d : '0) || v_bm != '1) operr++;
        end else begin
          operr++;
        end
        if (nops == 0) w0 = v_din;
        if (nops == 1) w1 = v_din;
        nops++;
      end
      if (v_done) done_c = c;
      if (mid_start) set_start(s3, c == 30);
    end
    chk("done_cycle", done_c, 10 * N + lat + 1);
    chk("op_count", nops, 10 * N);
    chk("op_stream_errors", operr, 0);
    chk("fail", v_fail, efail);
    chk("fail_addr", v_faddr, efa);
    chk("fail_data", v_fdata, efd);
    chk("idle_at_done", {v_busy, v_en, v_men, v_wen, v_ren, v_addr, v_din, v_bm}, '0);
    if (pat) begin
      chk("e0_even_write", w0, 16'h5555);
      chk("e0_odd_write", w1, 16'hAAAA);
    end
  endtask

  typedef struct {
    bit s3; bit pat; int fk; logic [AW-1:0] fa; int fb; bit fv; logic [AW-1:0] ca, cv;
    bit mid; bit ef; logic [AW-1:0] efa; logic [DW-1:0] efd;
  } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000};  // ideal, solid
    tbl[1] = '{0, 0, 1, 3, 5, 0, 0, 0, 0, 1, 3, 16'hFFDF};  // addr 3 bit 5 stuck-at-0
    tbl[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000};  // ideal, checkerboard
    tbl[3] = '{0, 0, 2, 0, 0, 0, 6, 2, 0, 1, 2, 16'hFFFE};  // write 6 flips bit 0 of 2
    tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};  // lat 3, start mid-run ignored
    tbl[5] = '{1, 0, 1, 3, 5, 0, 0, 0, 0, 1, 3, 16'hFFDF};  // lat 3, stuck-at
    tbl[6] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000};  // restart from DONE clears status

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_lat1", all_outs(0), '0);
    chk("reset_outs_lat3", all_outs(1), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_release", all_outs(0), '0);

    for (int i = 0; i < 7; i++) begin
      fk = tbl[i].fk; fa = tbl[i].fa; fb = tbl[i].fb; fv = tbl[i].fv; ca = tbl[i].ca; cv = tbl[i].cv;
      build_ref(tbl[i].pat);
      run(tbl[i].s3, tbl[i].pat, tbl[i].mid, tbl[i].ef, tbl[i].efa, tbl[i].efd);
    end

    // Reset asserted during element 3, then a clean rerun.
    fk = 0;
    sel = 0;
    @(negedge clk);
    pat_in = 1'b0;
    st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("mid_e3_active", {men1, busy1}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", all_outs(0), '0);
    @(posedge clk); #1;
    chk("no_op_in_reset", all_outs(0), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_mid_reset", all_outs(0), '0);
    build_ref(0);
    run(0, 0, 0, 0, '0, '0);

    for (int i = 0; i < 8; i++) begin
      fk = $urandom_range(2);
      fa = AW'($urandom_range(N - 1));
      fb = $urandom_range(DW - 1);
      fv = 1'($urandom_range(1));
      ca = AW'($urandom_range(N - 1));
      cv = AW'((int'(ca) + 1 + $urandom_range(N - 2)) % N);
      pat_in = 1'($urandom_range(1));
      build_ref(pat_in);
      run(i % 2 == 1, pat_in, 0, rf_fail, rf_fa, rf_fd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 SHALL have parameter DATA_W, default 16, SRAM word width in bits (legal 1..64).
REQ-002 SHALL have parameter ADDR_W, default 12, SRAM address width; depth N = 2**ADDR_W (legal 2..16).
REQ-003 SHALL have parameter READ_LAT, default 1, cycles from read-issue edge to the edge sampling sram_dout_i (legal 1..3).
REQ-004 Port clk_i  in  1  single clock; all logic on rising edge; the SRAM's BIST clock connects to the same net.
REQ-005 Port rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 Port start_i  in  1  one-cycle request to run the test.
REQ-007 Port pattern_i  in  1  0 = solid background (0 / all-ones); 1 = checkerboard (background inverted on odd addresses).
REQ-008 Port sram_dout_i  in  DATA_W  SRAM read data.
REQ-009 Port bist_en_o  out  1  selects BIST port in the SRAM mux.
REQ-010 Ports bist_men_o, bist_wen_o, bist_ren_o  out  1 each  SRAM BIST enables.
REQ-011 Port bist_addr_o  out  ADDR_W  SRAM BIST address.
REQ-012 Ports bist_din_o, bist_bm_o  out  DATA_W each  write data and bit mask.
REQ-013 Ports busy_o, done_o, fail_o  out  1 each  status.
REQ-014 Ports fail_addr_o  out  ADDR_W; fail_data_o  out  DATA_W  first-failure capture.

Function
REQ-015 SHALL run March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 down(r0); "0" = background B(a), "1" = ~B(a).
REQ-016 B(a) SHALL be all-zeros when pattern_i=0; when pattern_i=1, alternating 0101.. from bit 0 for even a and its inverse for odd a; pattern_i is latched at start.
REQ-017 States SHALL be IDLE, RUN, DRAIN, DONE; IDLE/DONE + start_i -> RUN; RUN after last E5 read -> DRAIN; DRAIN after READ_LAT cycles -> DONE.
REQ-018 start_i SHALL be ignored in RUN and DRAIN; start_i in DONE clears done_o, fail_o, fail_addr_o, fail_data_o and restarts.
REQ-019 All bist_* outputs SHALL be registered; exactly one SRAM operation is issued per cycle in RUN, with no idle cycles between ops or elements.
REQ-020 Op encoding: write = men=1, wen=1, ren=0; read = men=1, wen=0, ren=1; outside RUN men=wen=ren=0 and addr/din hold 0.
REQ-021 bist_bm_o SHALL be all-ones during RUN and 0 otherwise; bist_en_o SHALL equal busy_o.
REQ-022 Up elements SHALL address 0..N-1 and down elements N-1..0; address counter wraps without a dead cycle between elements.
REQ-023 Total ops SHALL be 10N; done_o SHALL rise exactly 10N+READ_LAT+1 cycles after the edge sampling start_i.
REQ-024 Expected data and address SHALL be pipelined READ_LAT deep; each read compares sram_dout_i against expected on the edge READ_LAT cycles after issue; writes are never compared.
REQ-025 On mismatch fail_o SHALL set sticky; fail_addr_o/fail_data_o capture only the first mismatch (address and raw read word).
REQ-026 Comparisons SHALL continue to end of test after a failure; the test does not abort.
REQ-027 busy_o SHALL be high in RUN and DRAIN; done_o high only in DONE and held until next start or reset.

Reset
REQ-028 rst_ni low SHALL immediately force IDLE and drive every output to 0, including mid-test; no SRAM op is issued while rst_ni is low.
REQ-029 After reset release the block SHALL stay in IDLE until start_i; the discarded partial test leaves no status.

Verification
REQ-030 ADDR_W=3, DATA_W=16, READ_LAT=1, ideal memory, pattern_i=0, start pulse -> 80 ops, done_o rises 82 cycles after start edge, fail_o=0, busy_o low with done_o.
REQ-031 Same config, bit 5 of address 3 stuck-at-0 -> first mismatch in E2 r1: fail_o=1, fail_addr_o=3, fail_data_o=16'hFFDF, done_o still at cycle 82.
REQ-032 pattern_i=1, ideal memory -> E0 writes 16'h5555 at even and 16'hAAAA at odd addresses; fail_o=0.
REQ-033 rst_ni pulsed low during E3 -> all outputs 0 in the same cycle; a new start then completes with done at 82 cycles, fail_o=0.
REQ-034 READ_LAT=3, ADDR_W=3 -> done_o at 84 cycles; start_i pulsed mid-RUN is ignored; start_i in DONE clears status and reruns.
REQ-035 Coupling fault (write 1 to address 6 flips bit 0 of address 2) -> fail_o=1, fail_addr_o=2, with capture of first mismatch only.
